// File: rtl/spi_pwm_timer.sv
// spi_pwm_timer: prescaled PWM/one-shot timer fed by SPI config registers; `SPI_PWM_SHADOW_EN` adds PERIOD/DUTY shadow registers
module spi_pwm_timer #(
    parameter int NUM_CFG    = 16,
    parameter int NUM_STATUS = 16,
    parameter int REG_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            ena,
    input  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    output logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic                            pwm_out
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [REG_WIDTH-1:0] ONE = REG_WIDTH'(1);

    logic [REG_WIDTH-1:0] cfg0, presc, cfg_period, cfg_duty, period, duty;
    logic [REG_WIDTH-1:0] cnt, pcnt, wrap_cnt;
    logic [1:0]           state;
    logic                 clr_q;
    logic                 en, oneshot, pol, clr_edge, running, tick, at_end, wrap, raw;
    logic                 unused_cfg;

    assign cfg0       = config_regs[0 +: REG_WIDTH];
    assign presc      = config_regs[REG_WIDTH +: REG_WIDTH];
    assign cfg_period = config_regs[2*REG_WIDTH +: REG_WIDTH];
    assign cfg_duty   = config_regs[3*REG_WIDTH +: REG_WIDTH];
    assign unused_cfg = ^config_regs;

    assign en       = cfg0[0];
    assign oneshot  = cfg0[1];
    assign pol      = cfg0[2];
    assign clr_edge = cfg0[3] & ~clr_q;
    assign running  = state == RUN;
    assign tick     = running && pcnt == presc;
    assign at_end   = cnt == period;
    assign wrap     = running && en && !clr_edge && tick && at_end;
    assign raw      = running && cnt < duty;

`ifdef SPI_PWM_SHADOW_EN
    logic [REG_WIDTH-1:0] act_period, act_duty;
    logic                 load;

    assign load   = ena && ((state == IDLE && en) || wrap);
    assign period = act_period;
    assign duty   = act_duty;

    // active PERIOD/DUTY follow the config only at run start and at each wrap
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            act_period <= '0;
            act_duty   <= '0;
        end else if (load) begin
            act_period <= cfg_period;
            act_duty   <= cfg_duty;
        end
    end
`else
    assign period = cfg_period;
    assign duty   = cfg_duty;
`endif

    // run/stop state machine, prescaler, period counter, wrap counter and registered output
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= IDLE;
            cnt      <= '0;
            pcnt     <= '0;
            wrap_cnt <= '0;
            clr_q    <= 1'b0;
            pwm_out  <= 1'b0;
        end else if (ena) begin
            clr_q    <= cfg0[3];
            pwm_out  <= raw ^ pol;
            wrap_cnt <= clr_edge ? '0 : wrap ? wrap_cnt + ONE : wrap_cnt;
            if (running) begin
                if (!en || clr_edge) begin
                    state <= en ? RUN : IDLE;
                    cnt   <= '0;
                    pcnt  <= '0;
                end else begin
                    pcnt  <= tick ? '0 : pcnt + ONE;
                    cnt   <= !tick ? cnt : at_end ? '0 : cnt + ONE;
                    state <= (tick && at_end && oneshot) ? DONE : RUN;
                end
            end else begin
                cnt   <= '0;
                pcnt  <= '0;
                state <= (state == IDLE) ? (en ? RUN : IDLE) : (en && !clr_edge) ? DONE : IDLE;
            end
        end
    end

    // status is a plain view of the registered fields
    always_comb begin
        status_regs = '0;
        status_regs[0 +: REG_WIDTH]           = cnt;
        status_regs[REG_WIDTH +: 3]           = {pwm_out, state};
        status_regs[2*REG_WIDTH +: REG_WIDTH] = wrap_cnt;
    end
endmodule
